mem_access_unit: RTL and testbench

MEM-stage data-memory access unit for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns load/store control from EX/MEM into requests on a variable-latency data bus using a req/ack handshake, and stalls the pipeline while an access is outstanding. It aligns store bytes to lanes, extracts and extends load data to the `read_data` value that MEM/WB captures, and flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Turns EX/MEM load/store control into a req/ack bus access, stalls the
// pipeline while the access is outstanding, lane-aligns stores, extracts and
// extends loads, and flags misaligned accesses and bus timeouts.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_i             MEM stage holds a valid instruction
//   mem_read_i          load
//   mem_write_i         store (wins if both read and write are set)
//   size_i              00 byte, 01 half, 1x word
//   unsigned_i          zero-extend loads
//   addr_i, wdata_i     byte address, store data
//   bus_req_o..wdata_o  registered bus request, held stable through WAIT
//   bus_ack_i/rdata_i   bus completion and read word
//   stall_o             pipeline freeze
//   read_data_o         extended load result for MEM/WB
//   misalign_o          combinational misalignment flag
//   bus_err_o           one-cycle timeout pulse in DONE
//
// state  | meaning
// IDLE   | no access outstanding; a new access is launched here
// WAIT   | request on the bus, waiting for ack or timeout
// DONE   | result valid; inputs still show the finished instruction
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stall_o,
   output logic [31:0] read_data_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  sz_q, sz_d;
   logic [1:0]  off_q, off_d;
   logic        uns_q, uns_d;

   logic        mem_op;
   logic        access;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] load_c;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign mem_op     = valid_i & (mem_read_i | mem_write_i);
   assign misalign_o = mem_op & (((size_i == 2'b01) & addr_i[0]) |
                                 (size_i[1] & (addr_i[1:0] != 2'b00)));
   assign access     = mem_op & ~misalign_o;
   // Gated by rst so the freeze releases the moment reset is applied.
   assign stall_o    = ~rst & (((state_q == S_IDLE) & access) | (state_q == S_WAIT));

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = wdata_i;
      case (size_i)
         2'b00: begin
            be_c    = 4'b0001 << addr_i[1:0];
            wdata_c = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the size/offset captured at launch, not the live inputs.
   always_comb begin
      lane_b = bus_rdata_i[8*off_q +: 8];
      lane_h = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      load_c = bus_rdata_i;
      case (sz_q)
         2'b00:   load_c = {{24{~uns_q & lane_b[7]}}, lane_b};
         2'b01:   load_c = {{16{~uns_q & lane_h[15]}}, lane_h};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      sz_d    = sz_q;
      off_d   = off_q;
      uns_d   = uns_q;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               state_d = S_WAIT;
               cnt_d   = 8'd0;
               req_d   = 1'b1;
               we_d    = mem_write_i;
               addr_d  = {addr_i[31:2], 2'b00};
               be_d    = be_c;
               wdata_d = wdata_c;
               sz_d    = size_i;
               off_d   = addr_i[1:0];
               uns_d   = unsigned_i;
            end else begin
               // Pipeline advances past a non-access instruction.
               rdata_d = 32'd0;
            end
         end
         S_WAIT: begin
            if (bus_ack_i) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               rdata_d = we_q ? 32'd0 : load_c;
            end else if (cnt_q == CNT_TC) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               rdata_d = 32'd0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         sz_q    <= 2'd0;
         off_q   <= 2'd0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         sz_q    <= sz_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
      end
   end

   assign bus_req_o   = req_q;
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_be_o    = be_q;
   assign bus_wdata_o = wdata_q;
   assign read_data_o = rdata_q;
   assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, mem_read_i, mem_write_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        stall_o, misalign_o, bus_err_o;
   logic [31:0] read_data_o;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .stall_o(stall_o), .read_data_o(read_data_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no_finish want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Reference model: byte-count/offset arithmetic straight from the bus rules.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [3:0] m_be(input int nb, input int off);
      logic [3:0] be = '0;
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] wd);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input int nb, input int off, input logic uns,
                                          input logic [31:0] rd);
      logic [31:0] v = rd >> (8 * off);
      logic [31:0] mask;
      if (nb == 4) return rd;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = v & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic do_idle(input logic ack);
      @(negedge clk);
      valid_i = $urandom_range(0, 1); mem_read_i = 1'b0; mem_write_i = 1'b0;
      bus_ack_i = ack;
      #1;
      chk("idle_stall", stall_o, 0);
      chk("idle_misalign", misalign_o, 0);
      @(posedge clk); #1;
      chk("idle_req", bus_req_o, 0);
      chk("idle_rdata", read_data_o, 0);
      chk("idle_err", bus_err_o, 0);
      bus_ack_i = 1'b0;
   endtask

   // k = ack delay in WAIT cycles; k >= TMO means no ack at all.
   task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdw, input int k);
      int nb = nbytes(sz);
      int off = int'(addr[1:0]);
      logic mis = ((nb == 2) && addr[0]) || ((nb == 4) && (addr[1:0] != 2'b00));
      logic is_mem = rd | wr;
      int stalls = 0;
      int reqs = 0;
      bit acked = 0;
      logic [31:0] exp_rd;
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; size_i = sz;
      unsigned_i = uns; addr_i = addr; wdata_i = wd; bus_ack_i = 1'b0;
      bus_rdata_i = $urandom;
      #1;
      chk("misalign", misalign_o, is_mem & mis);
      chk("first_err", bus_err_o, 0);
      if (!is_mem || mis) begin
         chk("nostall", stall_o, 0);
         @(posedge clk); #1;
         chk("noreq", bus_req_o, 0);
         chk("noacc_rdata", read_data_o, 0);
         return;
      end
      chk("first_req", bus_req_o, 0);
      if (stall_o) stalls++;
      @(posedge clk);
      for (int j = 0; j < TMO; j++) begin
         @(negedge clk);
         bus_ack_i = (j == k);
         bus_rdata_i = rdw;
         #1;
         if (bus_req_o) reqs++;
         if (stall_o) stalls++;
         chk("wait_we", bus_we_o, wr);
         chk("wait_addr", bus_addr_o, {addr[31:2], 2'b00});
         chk("wait_be", bus_be_o, m_be(nb, off));
         if (wr) chk("wait_wdata", bus_wdata_o, m_wdata(nb, wd));
         @(posedge clk);
         if (j == k) begin acked = 1; break; end
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      bus_rdata_i = $urandom;
      #1;
      exp_rd = (!acked || wr) ? 32'd0 : m_load(nb, off, uns, rdw);
      chk("done_req", bus_req_o, 0);
      chk("done_stall", stall_o, 0);
      chk("done_rdata", read_data_o, exp_rd);
      chk("done_err", bus_err_o, !acked);
      chk("stall_cycles", stalls, acked ? k + 2 : TMO + 1);
      chk("req_cycles", reqs, acked ? k + 1 : TMO);
      @(posedge clk);
   endtask

   initial begin
      rst = 1'b1;
      valid_i = 0; mem_read_i = 0; mem_write_i = 0; size_i = 0; unsigned_i = 0;
      addr_i = 0; wdata_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", bus_req_o, 0);
      chk("rst_we", bus_we_o, 0);
      chk("rst_addr", bus_addr_o, 0);
      chk("rst_be", bus_be_o, 0);
      chk("rst_wdata", bus_wdata_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_rdata", read_data_o, 0);
      chk("rst_err", bus_err_o, 0);
      rst = 1'b0;

      do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
      do_access(1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF1234, 0);
      do_access(1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF1234, 0);
      do_access(0, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 32'h0, 0);
      do_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0);
      do_access(0, 1, 2'b01, 0, 32'h11, 32'h1234, 32'h0, 0);
      do_access(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h11223344, TMO);
      do_idle(1'b1);
      do_access(1, 0, 2'b10, 0, 32'h304, 32'h0, 32'h55667788, TMO - 1);
      do_access(1, 1, 2'b11, 0, 32'h308, 32'hCAFEF00D, 32'h0, 1);

      for (int it = 0; it < 60; it++) begin
         logic [31:0] a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'(2 * $urandom_range(0, 1) * int'(a[0]));
         do_access($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 1), a, $urandom, $urandom, $urandom_range(0, TMO + 1));
         if ($urandom_range(0, 2) == 0) do_idle($urandom_range(0, 1));
      end

      // Reset in the second WAIT cycle abandons the access.
      @(negedge clk);
      valid_i = 1; mem_read_i = 1; mem_write_i = 0; size_i = 2'b10; addr_i = 32'h40;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_req", bus_req_o, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_req", bus_req_o, 0);
      chk("rst_mid_stall", stall_o, 0);
      valid_i = 0; mem_read_i = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
      #1;
      chk("post_rst_req", bus_req_o, 0);
      @(posedge clk);
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("post_ack_req", bus_req_o, 0);
      chk("post_ack_stall", stall_o, 0);
      chk("post_ack_rdata", read_data_o, 0);
      chk("post_ack_err", bus_err_o, 0);
      chk("post_ack_addr", bus_addr_o, 0);
      do_access(1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h0BADF00D, 1);
      do_idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
